sipo_deserializer: RTL and testbench

- Serial-in/parallel-out receiver. Collects an N-bit word one bit per accepted cycle, MSB first, using left shifts.
- Presents the word on a valid/ready output port and holds it until the consumer takes it.
- Sits at the receiving end of the accelerator's serial operand/result path, where a parallel-load left-shift register emits bits MSB first.
- Provides start/restart control, a bit counter, and sticky overrun detection.

---
 rtl/sipo_pkg.sv | 13 +
 rtl/sipo_shift_reg.sv | 22 ++
 rtl/sipo_deserializer.sv | 101 ++++++++++
 tb/tb_sipo_deserializer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out receiver:
// the FSM state encoding and the default word width.
package sipo_pkg;

    localparam int SIPO_N = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in left-shift register: new bits enter at bit 0, so the first
// bit received ends up at the MSB once N bits have been shifted in.
module sipo_shift_reg #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         sh_en,
    input  logic         bit_in,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (sh_en) begin
            q <= {q[N-2:0], bit_in};
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Collects N serial bits MSB first and presents the word on a valid/ready
// port, with restart control, a bit counter and sticky overrun detection.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter  int N  = SIPO_N,
    localparam int CW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bit_in,
    input  logic          bit_valid,
    input  logic          out_ready,
    output logic [N-1:0]  data_out,
    output logic          out_valid,
    output logic          busy,
    output logic [CW-1:0] bit_count,
    output logic          overrun
);

    state_t       state;
    logic [N-1:0] q;
    logic         sreg_clr;
    logic         sreg_sh_en;
    logic         sreg_msb_unused;

    // A start is only accepted in HOLD when the held word is consumed in the same cycle.
    assign sreg_clr        = start && ((state != ST_HOLD) || out_ready);
    assign sreg_sh_en      = (state == ST_COLLECT) && bit_valid && !start;
    assign sreg_msb_unused = q[N-1];

    sipo_shift_reg #(
        .N (N)
    ) u_shift_reg (
        .clk    (clk),
        .rst    (rst),
        .clr    (sreg_clr),
        .sh_en  (sreg_sh_en),
        .bit_in (bit_in),
        .q      (q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            bit_count <= '0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_COLLECT;
                        busy      <= 1'b1;
                        bit_count <= '0;
                        overrun   <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (start) begin
                        bit_count <= '0;
                        overrun   <= 1'b0;
                    end else if (bit_valid) begin
                        if (bit_count == CW'(N - 1)) begin
                            data_out  <= {q[N-2:0], bit_in};
                            out_valid <= 1'b1;
                            bit_count <= CW'(N);
                            state     <= ST_HOLD;
                        end else begin
                            bit_count <= bit_count + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (bit_valid) begin
                        overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        bit_count <= '0;
                        if (start) begin
                            state   <= ST_COLLECT;
                            overrun <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer: expected words are queued as they
// are serialised and popped when the receiver presents a completed word.
module tb_sipo_deserializer;

    localparam int N  = 16;
    localparam int CW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          bit_in;
    logic          bit_valid;
    logic          out_ready;
    logic [N-1:0]  data_out;
    logic          out_valid;
    logic          busy;
    logic [CW-1:0] bit_count;
    logic          overrun;

    int vectors     = 0;
    int miscompares = 0;
    logic [N-1:0] exp_q[$];

    sipo_deserializer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy),
        .bit_count (bit_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shifts the top nbits of word MSB first, checking the counter and that
    // out_valid rises only after the N-th bit.
    task automatic send_bits(input logic [N-1:0] word, input int nbits, input bit gapped);
        for (int k = 1; k <= nbits; k++) begin
            bit_in    = word[N-k];
            bit_valid = 1'b1;
            tick();
            bit_valid = 1'b0;
            vectors++;
            if (bit_count !== CW'(k) || out_valid !== (k == N)) begin
                miscompares++;
                $display("FAIL send_bit%0d: bit_count=%0d out_valid=%b, want %0d/%b",
                         k, bit_count, out_valid, k, (k == N));
            end
            if (gapped) begin
                tick();
                vectors++;
                if (bit_count !== CW'(k)) begin
                    miscompares++;
                    $display("FAIL gap_hold%0d: bit_count=%0d want %0d", k, bit_count, k);
                end
            end
        end
        bit_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || bit_count !== '0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL start: busy=%b bit_count=%0d overrun=%b, want 1/0/0",
                     busy, bit_count, overrun);
        end
    endtask

    task automatic pop_check(input string name);
        int n;
        logic [N-1:0] e;
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: out_valid never rose, got %b want 1", name, out_valid);
        end else if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: unexpected word %h, scoreboard empty", name, data_out);
        end else begin
            e = exp_q.pop_front();
            if (data_out !== e) begin
                miscompares++;
                $display("FAIL %s: data_out=%h want %h", name, data_out, e);
            end
        end
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || bit_count !== '0) begin
            miscompares++;
            $display("FAIL %s_handshake: out_valid=%b busy=%b bit_count=%0d, want 0/0/0",
                     name, out_valid, busy, bit_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if ({data_out, out_valid, busy, bit_count, overrun} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: data=%h v=%b busy=%b cnt=%0d ovr=%b, want all 0",
                     data_out, out_valid, busy, bit_count, overrun);
        end
        pulse_start();
        send_bits(16'hA5C3, 7, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({data_out, out_valid, busy, bit_count, overrun} !== '0) begin
            miscompares++;
            $display("FAIL reset_midword: data=%h v=%b busy=%b cnt=%0d ovr=%b, want all 0",
                     data_out, out_valid, busy, bit_count, overrun);
        end
        exp_q.push_back(16'h1234);
        pulse_start();
        send_bits(16'h1234, N, 1'b0);
        pop_check("reset_then_word");
        handshake("reset_then_word");
    endtask

    task automatic test_basic();
        exp_q.push_back(16'hA5C3);
        pulse_start();
        send_bits(16'hA5C3, N, 1'b0);
        pop_check("basic");
        handshake("basic");
    endtask

    task automatic test_gapped_backpressure();
        exp_q.push_back(16'h8001);
        pulse_start();
        send_bits(16'h8001, N, 1'b1);
        pop_check("gapped");
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (data_out !== 16'h8001 || out_valid !== 1'b1 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL backpressure_c%0d: data=%h v=%b busy=%b, want 8001/1/1",
                         c, data_out, out_valid, busy);
            end
        end
        handshake("gapped");
        vectors++;
        if (data_out !== 16'h8001) begin
            miscompares++;
            $display("FAIL retain_after_handshake: data_out=%h want 8001", data_out);
        end
    endtask

    task automatic test_overrun();
        exp_q.push_back(16'hFFFF);
        pulse_start();
        send_bits(16'hFFFF, N, 1'b0);
        bit_in    = 1'b0;
        bit_valid = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        bit_valid = 1'b0;
        vectors++;
        if (overrun !== 1'b1 || data_out !== 16'hFFFF || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: ovr=%b data=%h v=%b, want 1/ffff/1",
                     overrun, data_out, out_valid);
        end
        pop_check("overrun");
        handshake("overrun");
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: overrun=%b want 1", overrun);
        end
        pulse_start();
    endtask

    task automatic test_restart();
        pulse_start();
        send_bits(16'hABCD, 9, 1'b0);
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        vectors++;
        if (bit_count !== '0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL restart: cnt=%0d busy=%b v=%b, want 0/1/0", bit_count, busy, out_valid);
        end
        exp_q.push_back(16'h00FF);
        send_bits(16'h00FF, N, 1'b0);
        pop_check("restart");
        handshake("restart");
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(16'h1111);
        pulse_start();
        send_bits(16'h1111, N, 1'b0);
        pop_check("b2b_first");
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || bit_count !== '0) begin
            miscompares++;
            $display("FAIL b2b_gap: v=%b busy=%b cnt=%0d, want 0/1/0", out_valid, busy, bit_count);
        end
        exp_q.push_back(16'h2222);
        send_bits(16'h2222, N, 1'b0);
        pop_check("b2b_second");
        handshake("b2b_second");
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_gapped_backpressure();
        test_overrun();
        test_restart();
        test_back_to_back();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d words left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
